// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable clock divider
// with run / single-step / halt control and debounced step button.
module clk_tick_gen #(
  parameter int NUM_CH     = 5,
  parameter int CNT_W      = 32,
  parameter int DEB_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [1:0]              mode,
  input  logic                    step_btn,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_clk,
  output logic                    step_busy,
  output logic                    running
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_TH  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_WAIT,
    S_STEP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  term   [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] dclk_q;
  logic              adv;

  logic [DW-1:0] deb_cnt_q;
  logic          deb_lvl_q;
  logic          deb_lvl_d1_q;
  logic          press;

  logic mode_run;
  logic mode_step;
  logic mode_halt;

  assign mode_run  = (mode == 2'b00);
  assign mode_step = (mode == 2'b01);
  assign mode_halt = mode[1];

  // A press is the first cycle the debounced level is seen high.
  assign press = deb_lvl_q & ~deb_lvl_d1_q;

  // Counters only move in RUN or STEPPING, and never in a cycle
  // where the mode is pulling the FSM out of that state.
  assign adv = ((state_q == S_RUN) && mode_run) ||
               ((state_q == S_STEP) && !mode_halt);

  // Terminal count per channel; a zero divisor behaves as one.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      term[i] = '0;
      if (div_val[i*CNT_W +: CNT_W] != '0)
        term[i] = div_val[i*CNT_W +: CNT_W] - 1'b1;
      wrap[i] = (cnt_q[i] >= term[i]);
    end
  end

  // Divider counters, registered tick strobes and square outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
      tick_q <= '0;
      dclk_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        tick_q[i] <= 1'b0;
        if (adv && ch_en[i]) begin
          if (wrap[i]) begin
            cnt_q[i]  <= '0;
            tick_q[i] <= 1'b1;
            dclk_q[i] <= ~dclk_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // Step button debounce: saturating high-run counter plus edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q    <= '0;
      deb_lvl_q    <= 1'b0;
      deb_lvl_d1_q <= 1'b0;
    end else begin
      deb_lvl_d1_q <= deb_lvl_q;
      if (step_btn) begin
        if (deb_cnt_q != DEB_MAX)
          deb_cnt_q <= deb_cnt_q + 1'b1;
        if (deb_cnt_q >= DEB_TH)
          deb_lvl_q <= 1'b1;
      end else begin
        deb_cnt_q <= '0;
        deb_lvl_q <= 1'b0;
      end
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_HALT;
    else
      state_q <= state_d;
  end

  // Control FSM next-state; a step ends on the channel-0 wrap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALT: begin
        unique case (1'b1)
          mode_run:  state_d = S_RUN;
          mode_step: state_d = S_WAIT;
          default:   state_d = S_HALT;
        endcase
      end
      S_RUN: begin
        unique case (1'b1)
          mode_halt: state_d = S_HALT;
          mode_step: state_d = S_WAIT;
          default:   state_d = S_RUN;
        endcase
      end
      S_WAIT: begin
        unique case (1'b1)
          mode_run:  state_d = S_RUN;
          mode_halt: state_d = S_HALT;
          default:   state_d = press ? S_STEP : S_WAIT;
        endcase
      end
      S_STEP: begin
        if (mode_halt)
          state_d = S_HALT;
        else if (ch_en[0] && wrap[0])
          state_d = mode_run ? S_RUN : S_WAIT;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign tick      = tick_q;
  assign div_clk   = dclk_q;
  assign step_busy = (state_q == S_STEP);
  assign running   = (state_q == S_RUN) || (state_q == S_STEP);

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed scenarios plus random traffic,
// compared each cycle against a behavioural model.
module tb_clk_tick_gen;

  localparam int NC  = 5;
  localparam int CW  = 32;
  localparam int DEB = 4;

  localparam int C_HALT = 0;
  localparam int C_RUN  = 1;
  localparam int C_WAIT = 2;
  localparam int C_STEP = 3;

  logic              clk;
  logic              rst;
  logic [NC*CW-1:0]  div_val;
  logic [NC-1:0]     ch_en;
  logic [1:0]        mode;
  logic              step_btn;
  logic [NC-1:0]     tick;
  logic [NC-1:0]     div_clk;
  logic              step_busy;
  logic              running;

  int total;
  int bad;

  int unsigned m_cnt [NC];
  bit          m_tick [NC];
  bit          m_dclk [NC];
  int          m_ctl;
  int          m_hi;

  int n_tick0;
  int n_busy;

  clk_tick_gen #(
    .NUM_CH(NC),
    .CNT_W(CW),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .div_val(div_val),
    .ch_en(ch_en),
    .mode(mode),
    .step_btn(step_btn),
    .tick(tick),
    .div_clk(div_clk),
    .step_busy(step_busy),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_div(input int ch, input int unsigned v);
    div_val[ch*CW +: CW] = v;
  endtask

  // Reference: advance one clock using the inputs currently applied.
  task automatic model_clock();
    bit press;
    bit adv;
    bit w0;
    int unsigned d;
    int nxt;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = 0;
        m_tick[i] = 0;
        m_dclk[i] = 0;
      end
      m_ctl = C_HALT;
      m_hi = 0;
      return;
    end
    press = (m_hi == DEB);
    m_hi = step_btn ? ((m_hi < 1000) ? m_hi + 1 : m_hi) : 0;
    adv = (m_ctl == C_RUN && mode == 2'b00) ||
          (m_ctl == C_STEP && mode < 2);
    w0 = 0;
    for (int i = 0; i < NC; i++) begin
      d = div_val[i*CW +: CW];
      if (d == 0) d = 1;
      m_tick[i] = 0;
      if (adv && ch_en[i]) begin
        if (m_cnt[i] + 1 >= d) begin
          m_cnt[i] = 0;
          m_tick[i] = 1;
          m_dclk[i] = !m_dclk[i];
          if (i == 0) w0 = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    nxt = m_ctl;
    if (m_ctl == C_STEP) begin
      if (mode >= 2) nxt = C_HALT;
      else if (w0) nxt = (mode == 0) ? C_RUN : C_WAIT;
    end else if (mode >= 2) begin
      nxt = C_HALT;
    end else if (mode == 0) begin
      nxt = C_RUN;
    end else if (m_ctl == C_WAIT) begin
      nxt = press ? C_STEP : C_WAIT;
    end else begin
      nxt = C_WAIT;
    end
    m_ctl = nxt;
  endtask

  task automatic cyc();
    logic [NC-1:0] et;
    logic [NC-1:0] ed;
    model_clock();
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      et[i] = m_tick[i];
      ed[i] = m_dclk[i];
    end
    chk("tick", 32'(tick), 32'(et));
    chk("div_clk", 32'(div_clk), 32'(ed));
    chk("step_busy", 32'(step_busy), 32'(m_ctl == C_STEP));
    chk("running", 32'(running),
        32'(m_ctl == C_RUN || m_ctl == C_STEP));
    if (tick[0]) n_tick0++;
    if (step_busy) n_busy++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    mode = 2'b00;
    step_btn = 1'b0;
    ch_en = '1;
    div_val = '0;
    set_div(0, 3);
    set_div(1, 1);
    set_div(2, 0);
    set_div(3, 2);
    set_div(4, 5);
    run(2);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_run", 32'(running), 32'd0);
    rst = 1'b0;
    cyc();
    chk("first_tick", 32'(tick), 32'd0);
    chk("first_dclk", 32'(div_clk), 32'd0);
    run(30);

    do_reset();
    mode = 2'b01;
    set_div(0, 4);
    run(3);
    step_btn = 1'b1;
    run(2);
    step_btn = 1'b0;
    n_busy = 0;
    run(8);
    chk("short_press_busy", 32'(n_busy), 32'd0);
    n_tick0 = 0;
    n_busy = 0;
    step_btn = 1'b1;
    run(10);
    step_btn = 1'b0;
    run(10);
    chk("step_tick0", 32'(n_tick0), 32'd1);
    chk("step_busy_len", 32'(n_busy), 32'd4);

    do_reset();
    mode = 2'b01;
    set_div(0, 12);
    run(2);
    n_tick0 = 0;
    step_btn = 1'b1;
    run(6);
    step_btn = 1'b0;
    run(1);
    step_btn = 1'b1;
    run(6);
    step_btn = 1'b0;
    run(20);
    chk("second_press_tick0", 32'(n_tick0), 32'd1);

    do_reset();
    mode = 2'b00;
    set_div(0, 10);
    run(9);
    set_div(0, 5);
    run(20);

    set_div(1, 6);
    run(3);
    ch_en[1] = 1'b0;
    run(20);
    ch_en[1] = 1'b1;
    run(15);

    do_reset();
    mode = 2'b01;
    set_div(0, 9);
    run(2);
    step_btn = 1'b1;
    run(8);
    rst = 1'b1;
    cyc();
    chk("rst_step_tick", 32'(tick), 32'd0);
    chk("rst_step_busy", 32'(step_busy), 32'd0);
    rst = 1'b0;
    step_btn = 1'b0;
    mode = 2'b00;
    run(20);

    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0)
        mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0)
        ch_en[$urandom_range(0, NC - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 9) == 0)
          set_div($urandom_range(0, NC - 1), $urandom_range(20, 60));
        else
          set_div($urandom_range(0, NC - 1), $urandom_range(0, 9));
      end
      if ($urandom_range(0, 5) == 0)
        step_btn = ~step_btn;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
